// File: rtl/md_pos_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// md_pos_pkg : position-word layout and cell reader FSM encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package md_pos_pkg;

  localparam int POS_FIELD_W   = 32;
  localparam int DATA_WIDTH    = 3 * POS_FIELD_W;
  localparam int POSX_LSB      = 0;
  localparam int POSY_LSB      = 32;
  localparam int POSZ_LSB      = 64;
  localparam int CELL_CNT_ADDR = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CNT_REQ  = 3'd1,
    ST_CNT_WAIT = 3'd2,
    ST_STREAM   = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_FIN      = 3'd5
  } cell_rd_state_e;

endpackage
`default_nettype wire

// File: rtl/cell_rd_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cell_rd_fifo : synchronous fall-through FIFO with occupancy output
// Rev 1.0
// ---------------------------------------------------------------------------
module cell_rd_fifo #(
  parameter int WIDTH = 105,
  parameter int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [OCC_W-1:0] occupancy,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full      = (r_occ == OCC_W'(DEPTH));
  assign empty     = (r_occ == '0);
  assign occupancy = r_occ;
  assign head      = r_mem[r_rd_ptr];
  assign w_pop     = pop & ~empty;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (push)  r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/cell_pos_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cell_pos_reader : reads a cell's count word, then streams its positions
// Rev 1.0
// ---------------------------------------------------------------------------
module cell_pos_reader
  import md_pos_pkg::*;
#(
  parameter int DATA_WIDTH   = 3 * POS_FIELD_W,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  count_err,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last
);

  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W  = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int WAIT_W = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

  cell_rd_state_e        r_state;
  logic [WAIT_W-1:0]     r_wait;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_count_err;
  logic [RD_LATENCY-1:0] r_sr_vld;
  logic [ADDR_WIDTH-1:0] r_sr_idx [RD_LATENCY];

  logic [OCC_W-1:0]      w_inflight;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_full;
  logic                  w_empty;
  logic [ENT_W-1:0]      w_head;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_ret_idx;
  logic [ADDR_WIDTH-1:0] w_cnt_raw;
  logic [ADDR_WIDTH-1:0] w_cnt_clamped;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) w_inflight = w_inflight + OCC_W'(r_sr_vld[i]);
  end

  // A read may only launch if a FIFO slot is guaranteed for it on return.
  assign w_issue = (r_state == ST_STREAM) &&
                   (((OCC_W+1)'(w_inflight) + (OCC_W+1)'(w_occ)) < (OCC_W+1)'(FIFO_DEPTH));

  assign w_ret_idx     = r_sr_idx[RD_LATENCY-1];
  assign w_push        = r_sr_vld[RD_LATENCY-1] & ~w_full;
  assign w_pop         = out_valid & out_ready;
  assign w_cnt_raw     = mem_q[ADDR_WIDTH-1:0];
  assign w_cnt_clamped = (w_cnt_raw > MAX_CNT) ? MAX_CNT : w_cnt_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wait      <= '0;
      r_count     <= '0;
      r_rd_ptr    <= '0;
      r_addr      <= '0;
      r_count_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_CNT_REQ;
            r_count_err <= 1'b0;
          end
        end
        ST_CNT_REQ: begin
          r_addr  <= ADDR_WIDTH'(CELL_CNT_ADDR);
          r_wait  <= '0;
          r_state <= ST_CNT_WAIT;
        end
        ST_CNT_WAIT: begin
          if (r_wait == WAIT_W'(RD_LATENCY - 1)) begin
            r_count     <= w_cnt_clamped;
            r_count_err <= (w_cnt_raw > MAX_CNT);
            r_rd_ptr    <= ADDR_WIDTH'(1);
            r_state     <= (w_cnt_clamped == '0) ? ST_FIN : ST_STREAM;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_STREAM: begin
          if (w_issue) begin
            r_addr   <= r_rd_ptr;
            r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            if (r_rd_ptr == r_count) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && out_last) r_state <= ST_FIN;
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) r_sr_idx[i] <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        r_sr_vld[i] <= r_sr_vld[i-1];
        r_sr_idx[i] <= r_sr_idx[i-1];
      end
      r_sr_vld[0] <= w_issue;
      r_sr_idx[0] <= r_rd_ptr;
    end
  end

  cell_rd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({(w_ret_idx == r_count), w_ret_idx, mem_q}),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .occupancy (w_occ),
    .head      (w_head)
  );

  assign busy           = (r_state != ST_IDLE) && (r_state != ST_FIN);
  assign done           = (r_state == ST_FIN);
  assign count_err      = r_count_err;
  assign particle_count = r_count;
  assign mem_wren       = 1'b0;
  assign mem_rden       = (r_state == ST_CNT_REQ) | w_issue;
  assign mem_address    = (r_state == ST_CNT_REQ) ? ADDR_WIDTH'(CELL_CNT_ADDR) :
                          w_issue                 ? r_rd_ptr : r_addr;

  // Head is masked while empty so the stream reads as zero out of reset.
  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign out_index = w_empty ? '0 : w_head[DATA_WIDTH +: ADDR_WIDTH];
  assign out_last  = ~w_empty & w_head[ENT_W-1];

endmodule
`default_nettype wire

// File: tb/tb_cell_pos_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cell_pos_reader : scoreboard bench for cell_pos_reader
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cell_pos_reader;
  import md_pos_pkg::*;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int RL = 2;
  localparam int FD = 4;

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic busy, done, count_err, mem_rden, mem_wren, out_valid, out_last;
  logic [AW-1:0] particle_count, mem_address, out_index;
  logic [DW-1:0] mem_q, out_data;

  logic [DW-1:0] ram [256];
  logic [DW-1:0] ram_s1;

  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  int   hs, done_cnt, first_valid, last_hs, done_cyc, issued, max_addr;
  bit   wren_seen, prev_stall;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;

  cell_pos_reader #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .PARTICLE_NUM (PN),
    .RD_LATENCY   (RL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .count_err      (count_err),
    .particle_count (particle_count),
    .mem_address    (mem_address),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_q          (mem_q),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Two-register read path gives the RAM its 2-cycle latency.
  always @(posedge clk) begin
    ram_s1 <= ram[mem_address];
    mem_q  <= ram_s1;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else                 out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_wren) wren_seen = 1'b1;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_idx", out_index, prev_idx);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
      if (mem_rden && mem_address != 0) begin
        chk("room_on_issue", (issued - hs) < FD, 1);
        issued++;
        if (int'(mem_address) > max_addr) max_addr = int'(mem_address);
      end
      if (out_valid && out_ready) begin
        chk("q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e.d);
          chk("beat_idx", out_index, e.idx);
          chk("beat_last", out_last, e.last);
        end
        hs++;
        if (out_last) last_hs = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic launch(input logic [7:0] cnt_byte, input int mode,
                        output int n, output bit exp_err, output int t0);
    exp_t e;
    exp_err = (cnt_byte > 8'(PN - 1));
    n       = exp_err ? PN - 1 : int'(cnt_byte);
    ram[0]  = {$urandom, $urandom, 24'($urandom), cnt_byte};
    for (int i = 1; i <= n; i++) begin
      e.d = '0;
      e.d[POSX_LSB +: 32] = $urandom;
      e.d[POSY_LSB +: 32] = $urandom;
      e.d[POSZ_LSB +: 32] = $urandom;
      ram[i] = e.d;
      e.idx  = AW'(i);
      e.last = (i == n);
      exp_q.push_back(e);
    end
    hs = 0; done_cnt = 0; first_valid = -1; last_hs = -1; done_cyc = -1;
    issued = 0; max_addr = 0; wren_seen = 1'b0;
    ready_mode = mode;
    @(posedge clk); #1 start = 1'b1; t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_run(input int n, input bit exp_err, input int t0, input int mode);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("beats", hs, n);
    chk("particle_count", particle_count, n);
    chk("count_err", count_err, exp_err);
    chk("busy_idle", busy, 0);
    chk("max_rd_addr", max_addr, n);
    chk("no_wren", wren_seen, 0);
    if (n == 0) begin
      chk("zero_done_lat", done_cyc - t0, RL + 2);
      chk("zero_no_valid", first_valid < 0, 1);
    end else begin
      chk("first_valid_lat", first_valid - t0, 2 * RL + 3);
      chk("done_after_last", done_cyc - last_hs, 1);
      if (mode == 0) chk("throughput", last_hs - first_valid, n - 1);
    end
  endtask

  initial begin
    int n, t0;
    bit ee;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {busy, done, count_err, particle_count, mem_address, mem_rden,
                        mem_wren, out_valid, out_last, out_index, out_data}, '0);
    rst = 1'b0;

    launch(8'd3, 0, n, ee, t0);    finish_run(n, ee, t0, 0);
    launch(8'd0, 0, n, ee, t0);    finish_run(n, ee, t0, 0);
    launch(8'd10, 1, n, ee, t0);   finish_run(n, ee, t0, 1);
    launch(8'hFF, 0, n, ee, t0);   finish_run(n, ee, t0, 0);

    launch(8'd5, 0, n, ee, t0);
    for (int k = 0; k < 200 && hs < 2; k++) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_run(n, ee, t0, 0);

    launch(8'd8, 0, n, ee, t0);
    for (int k = 0; k < 200 && hs < 2; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_outputs", {busy, done, count_err, particle_count, mem_address, mem_rden,
                           mem_wren, out_valid, out_last, out_index, out_data}, '0);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    done_cnt = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_valid", out_valid, 0);

    launch(8'd8, 0, n, ee, t0);    finish_run(n, ee, t0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
